// File: rtl/q_bank_writer_if.sv
// Write-port bundle of the 16-entry Q-value bank: valid/ready write channel,
// clear control, status pulses and the sixteen registered entry buses.
interface q_bank_writer_if #(
    parameter int DW = 16
);
    logic          wr_valid;
    logic          wr_ready;
    logic [3:0]    wr_idx;
    logic [DW-1:0] wr_data;
    logic          wr_mode;
    logic          wr_ack;
    logic          clr_start;
    logic          busy;
    logic          clr_done;
    logic [DW-1:0] q0, q1, q2, q3, q4, q5, q6, q7;
    logic [DW-1:0] q8, q9, q10, q11, q12, q13, q14, q15;

    modport master (
        output wr_valid, wr_idx, wr_data, wr_mode, clr_start,
        input  wr_ready, wr_ack, busy, clr_done,
        input  q0, q1, q2, q3, q4, q5, q6, q7,
        input  q8, q9, q10, q11, q12, q13, q14, q15
    );

    modport slave (
        input  wr_valid, wr_idx, wr_data, wr_mode, clr_start,
        output wr_ready, wr_ack, busy, clr_done,
        output q0, q1, q2, q3, q4, q5, q6, q7,
        output q8, q9, q10, q11, q12, q13, q14, q15
    );
endinterface

// File: rtl/q_bank_writer.sv
// Write side of the 16-entry signed Q-value bank: overwrite, read-modify-write
// accumulate and a sequential clear engine. Define Q_SATURATE_EN to saturate accumulates.
module q_bank_writer #(
    parameter int            DW      = 16,
    parameter logic [DW-1:0] CLR_VAL = {DW{1'b0}}
) (
    input  logic            clk,
    input  logic            rst_n,
    q_bank_writer_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADD   = 2'd1,
        CLEAR = 2'd2
    } state_t;

    state_t        state_q;
    logic [DW-1:0] q_q [16];
    logic [3:0]    idx_q;
    logic [3:0]    cnt_q;
    logic [DW:0]   sum_q;
    logic [DW:0]   sum_d;
    logic [DW-1:0] fit_d;
    logic          ack_q;
    logic          done_q;
    logic          wr_fire_s;

    // Reduce the DW+1-bit accumulate result back to an entry value.
    function automatic logic [DW-1:0] fit(input logic [DW:0] s);
        logic [DW-1:0] r;
`ifdef Q_SATURATE_EN
        // The two top bits disagree only when the signed sum left the DW-bit range.
        if (s[DW] != s[DW-1]) begin
            r = s[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        end else begin
            r = s[DW-1:0];
        end
`else
        r = s[DW-1:0];
`endif
        return r;
    endfunction

    // Sign-extended sum for a pending accumulate and its fitted commit value.
    always_comb begin
        sum_d = {q_q[bus.wr_idx][DW-1], q_q[bus.wr_idx]}
              + {bus.wr_data[DW-1], bus.wr_data};
        fit_d = fit(sum_q);
    end

    assign bus.wr_ready = (state_q == IDLE) && !bus.clr_start;
    assign wr_fire_s    = bus.wr_valid && bus.wr_ready;
    assign bus.busy     = (state_q != IDLE);
    assign bus.wr_ack   = ack_q;
    assign bus.clr_done = done_q;

    // Bank state machine: entry updates, clear sequencing and status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 4'd0;
            cnt_q   <= 4'd0;
            sum_q   <= {(DW+1){1'b0}};
            ack_q   <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                q_q[i] <= {DW{1'b0}};
            end
        end else begin
            ack_q  <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.clr_start) begin
                        state_q <= CLEAR;
                        cnt_q   <= 4'd0;
                    end else if (wr_fire_s) begin
                        if (bus.wr_mode) begin
                            idx_q   <= bus.wr_idx;
                            sum_q   <= sum_d;
                            state_q <= ADD;
                        end else begin
                            q_q[bus.wr_idx] <= bus.wr_data;
                            ack_q           <= 1'b1;
                        end
                    end
                end
                ADD: begin
                    q_q[idx_q] <= fit_d;
                    ack_q      <= 1'b1;
                    state_q    <= IDLE;
                end
                CLEAR: begin
                    q_q[cnt_q] <= CLR_VAL;
                    cnt_q      <= cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.q0  = q_q[0];
    assign bus.q1  = q_q[1];
    assign bus.q2  = q_q[2];
    assign bus.q3  = q_q[3];
    assign bus.q4  = q_q[4];
    assign bus.q5  = q_q[5];
    assign bus.q6  = q_q[6];
    assign bus.q7  = q_q[7];
    assign bus.q8  = q_q[8];
    assign bus.q9  = q_q[9];
    assign bus.q10 = q_q[10];
    assign bus.q11 = q_q[11];
    assign bus.q12 = q_q[12];
    assign bus.q13 = q_q[13];
    assign bus.q14 = q_q[14];
    assign bus.q15 = q_q[15];
endmodule

// File: tb/tb_q_bank_writer.sv
// Self-checking bench for q_bank_writer: directed vector table, hand-written
// clear/reset sequences and randomized traffic against a queue-based reference model.
module tb_q_bank_writer;
    localparam int          DW  = 16;
    localparam logic [15:0] CLR = 16'h0100;
`ifdef Q_SATURATE_EN
    localparam logic [15:0] OVF_P = 16'h7FFF;
    localparam logic [15:0] OVF_N = 16'h8000;
`else
    localparam logic [15:0] OVF_P = 16'h8010;
    localparam logic [15:0] OVF_N = 16'h7FF5;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    q_bank_writer_if #(.DW(DW)) bus ();
    q_bank_writer #(.DW(DW), .CLR_VAL(CLR)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic        v;
        logic [3:0]  idx;
        logic [15:0] data;
        logic        m;
        logic        c;
        logic [3:0]  ci;
        logic [15:0] ev;
        logic        ea;
        logic        er;
    } vec_t;

    // Scheduled future bank updates: one per accumulate, sixteen per clear.
    typedef struct {
        int          idx;
        logic [15:0] val;
        bit          ack;
        bit          done;
    } op_t;

    op_t         pend[$];
    logic [15:0] m[16];
    bit          exp_ack;
    bit          exp_done;
    int          checks   = 0;
    int          failures = 0;
    vec_t        tbl[12];

    function automatic logic [15:0] read_q(int k);
        case (k)
            0: return bus.q0;    1: return bus.q1;    2: return bus.q2;    3: return bus.q3;
            4: return bus.q4;    5: return bus.q5;    6: return bus.q6;    7: return bus.q7;
            8: return bus.q8;    9: return bus.q9;    10: return bus.q10;  11: return bus.q11;
            12: return bus.q12;  13: return bus.q13;  14: return bus.q14;  default: return bus.q15;
        endcase
    endfunction

    function automatic logic [15:0] fitm(logic [15:0] a, logic [15:0] b);
        int s;
        s = int'($signed(a)) + int'($signed(b));
`ifdef Q_SATURATE_EN
        if (s > 32767) s = 32767;
        else if (s < -32768) s = -32768;
`endif
        return s[15:0];
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the reference model by one rising edge using the currently driven inputs.
    task automatic model_edge();
        op_t o;
        exp_ack  = 1'b0;
        exp_done = 1'b0;
        if (pend.size() > 0) begin
            o = pend.pop_front();
            m[o.idx] = o.val;
            exp_ack  = o.ack;
            exp_done = o.done;
        end else if (bus.clr_start) begin
            for (int k = 0; k < 16; k++) pend.push_back('{k, CLR, 1'b0, (k == 15)});
        end else if (bus.wr_valid) begin
            if (!bus.wr_mode) begin
                m[bus.wr_idx] = bus.wr_data;
                exp_ack = 1'b1;
            end else begin
                pend.push_back('{int'(bus.wr_idx), fitm(m[bus.wr_idx], bus.wr_data), 1'b1, 1'b0});
            end
        end
    endtask

    task automatic check_all(string tag);
        bit bad;
        bad = 1'b0;
        checks++;
        for (int k = 0; k < 16; k++) begin
            if (read_q(k) !== m[k]) begin
                bad = 1'b1;
                $display("FAIL %s_q%0d actual=%h expected=%h at %0t", tag, k, read_q(k), m[k], $time);
            end
        end
        if (bad) failures++;
        chk({tag, "_ack"},   bus.wr_ack,   exp_ack);
        chk({tag, "_done"},  bus.clr_done, exp_done);
        chk({tag, "_busy"},  bus.busy,     pend.size() != 0);
        chk({tag, "_ready"}, bus.wr_ready, (pend.size() == 0) && !bus.clr_start);
    endtask

    task automatic drive(logic v, logic [3:0] idx, logic [15:0] data, logic md, logic c);
        bus.wr_valid  = v;
        bus.wr_idx    = idx;
        bus.wr_data   = data;
        bus.wr_mode   = md;
        bus.clr_start = c;
    endtask

    task automatic cycle(string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    // Asynchronous reset pulse between edges; entries must drop to zero at once.
    task automatic mid_reset(string tag);
        rst_n = 1'b0;
        pend.delete();
        for (int k = 0; k < 16; k++) m[k] = 16'h0000;
        exp_ack  = 1'b0;
        exp_done = 1'b0;
        drive(1'b0, 4'd0, 16'h0000, 1'b0, 1'b0);
        #2;
        check_all(tag);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int done_at;
        int acks;
        tbl[0]  = '{1'b1, 4'd3, 16'h1234, 1'b0, 1'b0, 4'd3, 16'h1234, 1'b1, 1'b1};
        tbl[1]  = '{1'b1, 4'd3, 16'hFFFE, 1'b1, 1'b0, 4'd3, 16'h1234, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 4'd3, 16'h1232, 1'b1, 1'b1};
        tbl[3]  = '{1'b1, 4'd5, 16'h7FF0, 1'b0, 1'b0, 4'd5, 16'h7FF0, 1'b1, 1'b1};
        tbl[4]  = '{1'b1, 4'd5, 16'h0020, 1'b1, 1'b0, 4'd5, 16'h7FF0, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 4'd5, OVF_P,    1'b1, 1'b1};
        tbl[6]  = '{1'b1, 4'd6, 16'h8005, 1'b0, 1'b0, 4'd6, 16'h8005, 1'b1, 1'b1};
        tbl[7]  = '{1'b1, 4'd6, 16'hFFF0, 1'b1, 1'b0, 4'd6, 16'h8005, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 4'd6, OVF_N,    1'b1, 1'b1};
        tbl[9]  = '{1'b1, 4'd7, 16'h0100, 1'b0, 1'b0, 4'd7, 16'h0100, 1'b1, 1'b1};
        tbl[10] = '{1'b1, 4'd7, 16'h0001, 1'b1, 1'b0, 4'd7, 16'h0100, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 4'd0, 16'h0000, 1'b0, 1'b0, 4'd7, 16'h0101, 1'b1, 1'b1};

        for (int k = 0; k < 16; k++) m[k] = 16'h0000;
        exp_ack  = 1'b0;
        exp_done = 1'b0;
        drive(1'b0, 4'd0, 16'h0000, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #4;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_all("reset");

        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].idx, tbl[i].data, tbl[i].m, tbl[i].c);
            cycle("tbl");
            chk("tbl_q",     read_q(tbl[i].ci), tbl[i].ev);
            chk("tbl_ack",   bus.wr_ack,        tbl[i].ea);
            chk("tbl_ready", bus.wr_ready,      tbl[i].er);
        end

        // Fill every entry with a nonzero value, then clear with a colliding write.
        for (int k = 0; k < 16; k++) begin
            drive(1'b1, k[3:0], 16'(k) * 16'h0101 + 16'h0011, 1'b0, 1'b0);
            cycle("fill");
        end
        drive(1'b1, 4'd4, 16'hDEAD, 1'b0, 1'b1);
        #1;
        chk("clr_beats_wr_ready", bus.wr_ready, 1'b0);
        cycle("clr_start");
        chk("clr_no_write", read_q(4), 16'h0415);
        done_at = -1;
        for (int e = 1; e <= 16; e++) begin
            drive(1'b0, 4'd0, 16'h0000, 1'b0, (e == 5));
            cycle("clear");
            chk("clr_entry", read_q(e - 1), CLR);
            chk("clr_busy", bus.busy, (e < 16));
            if (bus.clr_done && done_at < 0) done_at = e;
        end
        chk("clr_done_cycle", done_at, 16);
        drive(1'b0, 4'd0, 16'h0000, 1'b0, 1'b0);
        cycle("clr_after");

        // Reset in the middle of a clear, right after entry 7 was written.
        drive(1'b0, 4'd0, 16'h0000, 1'b0, 1'b1);
        cycle("rclr_start");
        drive(1'b0, 4'd0, 16'h0000, 1'b0, 1'b0);
        repeat (8) cycle("rclr");
        mid_reset("rst_clr");
        repeat (3) cycle("rst_clr_idle");
        chk("rst_clr_ready", bus.wr_ready, 1'b1);

        // Reset while an accumulate is pending.
        drive(1'b1, 4'd2, 16'h0050, 1'b0, 1'b0);
        cycle("radd_ow");
        drive(1'b1, 4'd2, 16'h0001, 1'b1, 1'b0);
        cycle("radd_acc");
        chk("radd_busy", bus.busy, 1'b1);
        mid_reset("rst_add");
        repeat (2) cycle("rst_add_idle");
        chk("rst_add_q2", read_q(2), 16'h0000);
        chk("rst_add_ready", bus.wr_ready, 1'b1);

        // Back-to-back overwrites with wr_valid held high.
        acks = 0;
        for (int k = 0; k < 16; k++) begin
            drive(1'b1, k[3:0], 16'(k) * 16'h0101, 1'b0, 1'b0);
            cycle("b2b");
            if (bus.wr_ack) acks++;
            chk("b2b_q", read_q(k), 16'(k) * 16'h0101);
        end
        chk("b2b_acks", acks, 16);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            logic [15:0] d;
            case ($urandom_range(0, 3))
                0:       d = 16'h7FF8 + 16'($urandom_range(0, 15));
                1:       d = 16'h8000 + 16'($urandom_range(0, 15));
                default: d = 16'($urandom);
            endcase
            drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), d,
                  1'($urandom_range(0, 1)), ($urandom_range(0, 39) == 0));
            cycle("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
